// File: rtl/alkcflag_pkg.sv
// Shared op encoding and single-flag next-value function for the ALKC
// scratch carry-flag file.
package alkcflag_pkg;

  localparam logic [2:0] ALKF_NOP = 3'd0;
  localparam logic [2:0] ALKF_SUB = 3'd1;
  localparam logic [2:0] ALKF_ADD = 3'd2;
  localparam logic [2:0] ALKF_SHR = 3'd3;
  localparam logic [2:0] ALKF_SHL = 3'd4;
  localparam logic [2:0] ALKF_SET = 3'd5;
  localparam logic [2:0] ALKF_CLR = 3'd6;
  localparam logic [2:0] ALKF_TOG = 3'd7;

  // Next value of one flag; SUB stores borrow, i.e. the inverted carry.
  function automatic logic alkf_next(input logic [2:0] op, input logic cur,
                                     input logic c, input logic shr,
                                     input logic shl);
    logic nxt_s;
    case (op)
      ALKF_NOP: nxt_s = cur;
      ALKF_SUB: nxt_s = ~c;
      ALKF_ADD: nxt_s = c;
      ALKF_SHR: nxt_s = shr;
      ALKF_SHL: nxt_s = shl;
      ALKF_SET: nxt_s = 1'b1;
      ALKF_CLR: nxt_s = 1'b0;
      ALKF_TOG: nxt_s = ~cur;
      default:  nxt_s = cur;
    endcase
    return nxt_s;
  endfunction

endpackage

// File: rtl/alkcflag_stack.sv
// Save/restore LIFO for the flag vector with sticky overflow/underflow.
// Simultaneous push and pop leave the stack untouched.
module alkcflag_stack #(
  parameter int N_FLAGS = 4,
  parameter int DEPTH   = 4,
  localparam int CNTW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [N_FLAGS-1:0] din,
  output logic [N_FLAGS-1:0] top,
  output logic [CNTW-1:0]    cnt,
  output logic               ovf,
  output logic               unf
);
  import alkcflag_pkg::*;

  logic [N_FLAGS-1:0] mem_r [DEPTH];
  logic [CNTW-1:0]    cnt_r;
  logic               ovf_r;
  logic               unf_r;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [N_FLAGS-1:0] top_s;

  // Qualify requests and read the current top entry.
  always_comb begin
    push_s  = push & ~pop;
    pop_s   = pop & ~push;
    full_s  = (cnt_r == CNTW'(DEPTH));
    empty_s = (cnt_r == {CNTW{1'b0}});
    top_s   = {N_FLAGS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_r == CNTW'(i + 1)) begin
        top_s = mem_r[i];
      end else begin
        top_s = top_s;
      end
    end
  end

  // Occupancy counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNTW{1'b0}};
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (push_s) begin
      if (full_s) begin
        ovf_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNTW'(1);
      end
    end else if (pop_s) begin
      if (empty_s) begin
        unf_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r - CNTW'(1);
      end
    end
  end

  // Entry storage; contents need no reset since cnt gates visibility.
  always_ff @(posedge clk) begin
    if (push_s && !full_s && !reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_r == CNTW'(i)) begin
          mem_r[i] <= din;
        end
      end
    end
  end

  assign top = top_s;
  assign cnt = cnt_r;
  assign ovf = ovf_r;
  assign unf = unf_r;

endmodule

// File: rtl/alkcflag_file.sv
// Scratch carry-flag file: N_FLAGS microcode carry flags with set/clear/
// toggle ops and a save/restore stack; feeds the ALU carry-in mux.
module alkcflag_file #(
  parameter int N_FLAGS = 4,
  parameter int DEPTH   = 4,
  localparam int IDXW   = (N_FLAGS > 1) ? $clog2(N_FLAGS) : 1,
  localparam int CNTW   = $clog2(DEPTH + 1)
) (
  input  logic               qdclk_l,
  input  logic               reset_h,
  input  logic               long_lit_l,
  input  logic [2:0]         op_h,
  input  logic [IDXW-1:0]    sel_h,
  input  logic               c32_in_h,
  input  logic               sout_shr_h,
  input  logic               sout_shl_h,
  input  logic               push_h,
  input  logic               pop_h,
  output logic [N_FLAGS-1:0] flags_h,
  output logic               sel_flag_h,
  output logic [CNTW-1:0]    stk_cnt_h,
  output logic               stk_ovf_h,
  output logic               stk_unf_h
);
  import alkcflag_pkg::*;

  logic [N_FLAGS-1:0] flags_r;
  logic [N_FLAGS-1:0] flags_nxt_s;
  logic [N_FLAGS-1:0] base_s;
  logic [N_FLAGS-1:0] stk_top_s;
  logic [CNTW-1:0]    stk_cnt_s;
  logic [2:0]         op_eff_s;
  logic               restore_s;
  logic               sel_flag_s;

  alkcflag_stack #(
    .N_FLAGS(N_FLAGS),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk  (qdclk_l),
    .reset(reset_h),
    .push (push_h),
    .pop  (pop_h),
    .din  (flags_r),
    .top  (stk_top_s),
    .cnt  (stk_cnt_s),
    .ovf  (stk_ovf_h),
    .unf  (stk_unf_h)
  );

  // Op qualification, restore merge and per-flag next value.
  always_comb begin
    if (!long_lit_l) begin
      op_eff_s = ALKF_NOP;
    end else if (int'(sel_h) >= N_FLAGS) begin
      op_eff_s = ALKF_NOP;
    end else begin
      op_eff_s = op_h;
    end
    restore_s = pop_h & ~push_h & (stk_cnt_s != {CNTW{1'b0}});
    if (restore_s) begin
      base_s = stk_top_s;
    end else begin
      base_s = flags_r;
    end
    flags_nxt_s = base_s;
    for (int i = 0; i < N_FLAGS; i++) begin
      if (sel_h == IDXW'(i)) begin
        flags_nxt_s[i] = alkf_next(op_eff_s, base_s[i], c32_in_h,
                                   sout_shr_h, sout_shl_h);
      end else begin
        flags_nxt_s[i] = base_s[i];
      end
    end
  end

  // Selected-flag readback from registered state only.
  always_comb begin
    sel_flag_s = 1'b0;
    for (int i = 0; i < N_FLAGS; i++) begin
      if (sel_h == IDXW'(i)) begin
        sel_flag_s = flags_r[i];
      end else begin
        sel_flag_s = sel_flag_s;
      end
    end
  end

  // Live flag register.
  always_ff @(posedge qdclk_l) begin
    if (reset_h) begin
      flags_r <= {N_FLAGS{1'b0}};
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

  assign flags_h    = flags_r;
  assign sel_flag_h = sel_flag_s;
  assign stk_cnt_h  = stk_cnt_s;

endmodule

// File: tb/tb_alkcflag_file.sv
// Directed table-driven bench for alkcflag_file (N_FLAGS=4, DEPTH=4).
module tb_alkcflag_file;
  import alkcflag_pkg::*;

  logic       clk = 1'b0;
  logic       reset_h, long_lit_l, c32_in_h, sout_shr_h, sout_shl_h;
  logic       push_h, pop_h;
  logic [2:0] op_h;
  logic [1:0] sel_h;
  logic [3:0] flags_h;
  logic       sel_flag_h;
  logic [2:0] stk_cnt_h;
  logic       stk_ovf_h, stk_unf_h;

  int n_chk = 0;
  int n_pass = 0;

  alkcflag_file #(.N_FLAGS(4), .DEPTH(4)) dut (
    .qdclk_l   (clk),
    .reset_h   (reset_h),
    .long_lit_l(long_lit_l),
    .op_h      (op_h),
    .sel_h     (sel_h),
    .c32_in_h  (c32_in_h),
    .sout_shr_h(sout_shr_h),
    .sout_shl_h(sout_shl_h),
    .push_h    (push_h),
    .pop_h     (pop_h),
    .flags_h   (flags_h),
    .sel_flag_h(sel_flag_h),
    .stk_cnt_h (stk_cnt_h),
    .stk_ovf_h (stk_ovf_h),
    .stk_unf_h (stk_unf_h)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ll;
    logic [2:0] op;
    logic [1:0] sel;
    logic       c;
    logic       shr;
    logic       shl;
    logic       push;
    logic       pop;
    logic [3:0] ef;
    logic [2:0] ec;
    logic       eo;
    logic       eu;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic ll, input logic [2:0] op,
                             input logic [1:0] sel, input logic c, input logic shr,
                             input logic shl, input logic push, input logic pop,
                             input logic [3:0] ef, input logic [2:0] ec,
                             input logic eo, input logic eu);
    vec_t r;
    r.rst = rst; r.ll = ll; r.op = op; r.sel = sel; r.c = c; r.shr = shr;
    r.shl = shl; r.push = push; r.pop = pop; r.ef = ef; r.ec = ec;
    r.eo = eo; r.eu = eu;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s (row %0d): got %0h expected %0h", name, row, got, exp);
    end
  endtask

  initial begin
    logic [3:0] ef_v;
    reset_h = 1'b0; long_lit_l = 1'b1; op_h = ALKF_NOP; sel_h = 2'd0;
    c32_in_h = 1'b0; sout_shr_h = 1'b0; sout_shl_h = 1'b0;
    push_h = 1'b0; pop_h = 1'b0;

    //        rst   ll    op        sel   c     shr   shl   push  pop   flags    cnt   ovf   unf
    tbl.push_back(v(1'b1, 1'b1, ALKF_SET, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_ADD, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SUB, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, ALKF_SET, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SHR, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SET, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SET, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1011, 3'd1, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_TOG, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1110, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SHL, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_CLR, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_TOG, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_ADD, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SUB, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 3'd0, 1'b0, 1'b0));
    // fill to full, then one extra push
    tbl.push_back(v(1'b0, 1'b1, ALKF_CLR, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 3'd1, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SET, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 3'd2, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SET, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1110, 3'd3, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_CLR, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 3'd4, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_TOG, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1011, 3'd4, 1'b1, 1'b0));
    // drain in reverse order, then pop on empty
    tbl.push_back(v(1'b0, 1'b1, ALKF_NOP, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1110, 3'd3, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_NOP, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 3'd2, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_NOP, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 3'd1, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_NOP, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, 3'd0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_NOP, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, 3'd0, 1'b1, 1'b1));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SET, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0111, 3'd0, 1'b1, 1'b1));
    // reset clears sticky flags; simultaneous push/pop
    tbl.push_back(v(1'b1, 1'b1, ALKF_NOP, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_NOP, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd1, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SET, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 3'd2, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SET, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 3'd2, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_NOP, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 3'd1, 1'b0, 1'b0));
    // three entries then reset mid-operation
    tbl.push_back(v(1'b0, 1'b1, ALKF_SET, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 3'd2, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SET, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 3'd2, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SET, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 3'd2, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_SET, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 3'd3, 1'b0, 1'b0));
    tbl.push_back(v(1'b1, 1'b1, ALKF_CLR, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, ALKF_ADD, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0));

    @(negedge clk);
    for (int r = 0; r < tbl.size(); r++) begin
      reset_h = tbl[r].rst; long_lit_l = tbl[r].ll; op_h = tbl[r].op;
      sel_h = tbl[r].sel; c32_in_h = tbl[r].c; sout_shr_h = tbl[r].shr;
      sout_shl_h = tbl[r].shl; push_h = tbl[r].push; pop_h = tbl[r].pop;
      @(posedge clk);
      #1;
      ef_v = tbl[r].ef;
      chk("flags", r, 32'(flags_h), 32'(ef_v));
      chk("sel_flag", r, 32'(sel_flag_h), 32'(ef_v[tbl[r].sel]));
      chk("stk_cnt", r, 32'(stk_cnt_h), 32'(tbl[r].ec));
      chk("stk_ovf", r, 32'(stk_ovf_h), 32'(tbl[r].eo));
      chk("stk_unf", r, 32'(stk_unf_h), 32'(tbl[r].eu));
    end

    // flags now 4'b0001: readback follows sel_h without a clock edge
    reset_h = 1'b0; push_h = 1'b0; pop_h = 1'b0; op_h = ALKF_NOP;
    sel_h = 2'd1;
    #1;
    chk("sel_flag_comb1", 100, 32'(sel_flag_h), 32'd0);
    sel_h = 2'd0;
    #1;
    chk("sel_flag_comb0", 101, 32'(sel_flag_h), 32'd1);

    // carry input change must not reach outputs before an edge
    op_h = ALKF_SUB; sel_h = 2'd0; c32_in_h = 1'b0;
    #1;
    c32_in_h = 1'b1;
    #1;
    chk("no_comb_c32", 102, 32'(flags_h), 32'h1);
    @(posedge clk);
    #1;
    chk("sub_c1", 103, 32'(flags_h), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alkcflag_file.md
Name: alkcflag_file

Overview:
- Parametrised successor to the single ALKC microarchitectural carry flag in the DC615 ALK (ALU Control) FUB set.
- Holds N_FLAGS independent scratch carry flags. Microcode and the mul/div state machine use them to chain carries, and shift-outs in both directions, without touching PSL.C.
- Adds set/clear/toggle ops and a save/restore stack of depth DEPTH, so microcode subroutines can preserve flags across calls.
- Sits between the ALU field decode (ALK) and the ALU carry-in mux on the DPM.

Parameters:
- N_FLAGS, 4, number of scratch carry flags (1..16).
- DEPTH, 4, save-stack entries, each N_FLAGS bits wide (1..16).
- IDXW, derived localparam = max(1, clog2(N_FLAGS)); not overridable.

Ports:
- qdclk_l  in  1  clock; all state updates on its rising edge.
- reset_h  in  1  synchronous active-high reset.
- long_lit_l  in  1  low = current micro-op is long-literal; suppresses op_h (forced to NOP).
- op_h  in  3  flag op, encoded per package.
- sel_h  in  IDXW  index of the flag that op_h targets.
- c32_in_h  in  1  ALU carry out.
- sout_shr_h  in  1  ALU bit-0 shift-out (right shift).
- sout_shl_h  in  1  ALU MSB shift-out (left shift).
- push_h  in  1  push the live flag vector onto the stack.
- pop_h  in  1  restore the flag vector from the stack.
- flags_h  out  N_FLAGS  registered live flag vector.
- sel_flag_h  out  1  flags_h[sel_h]; combinational from the registered state.
- stk_cnt_h  out  clog2(DEPTH+1)  occupied stack entries.
- stk_ovf_h  out  1  sticky: a push arrived while full.
- stk_unf_h  out  1  sticky: a pop arrived while empty.

Behaviour:
- Reset, synchronous, when reset_h=1 at a clock edge:
  - flags_h=0, stk_cnt_h=0, stk_ovf_h=0, stk_unf_h=0.
  - Stack contents are don't-care.
  - Reset overrides every other input that cycle.
- Op encoding and next value of flags[sel]; unselected flags hold:
  - NOP=0: hold.
  - SUB=1: ~c32_in_h.
  - ADD=2: c32_in_h.
  - SHR=3: sout_shr_h.
  - SHL=4: sout_shl_h.
  - SET=5: 1.
  - CLR=6: 0.
  - TOG=7: ~flags[sel].
- long_lit_l=0 forces NOP.
- sel_h >= N_FLAGS (non-power-of-2 N_FLAGS) forces NOP.
- Latency: an op applies at the next edge, so flags_h reflects it one cycle later.
- Push, push_h=1 and pop_h=0:
  - If not full: stack[cnt] <= the pre-update flags_h value, and cnt++.
  - If full (cnt=DEPTH): stack and cnt unchanged; stk_ovf_h <= 1.
  - The op applies to the live flags in the same cycle.
- Pop, pop_h=1 and push_h=0:
  - If not empty: base <= stack[cnt-1], and cnt--.
  - If empty: base <= flags_h; stk_unf_h <= 1.
  - The op then applies on top of base, so an op in a pop cycle modifies the restored value. TOG and SUB/ADD semantics use base[sel].
- push_h and pop_h both 1: treated as neither for the stack. No stack/cnt change, no error flag set; the op still applies.
- Sticky error flags clear only on reset.
- Stack is a LIFO; entries other than the top are never observable except via pop.
- No combinational path from c32_in_h or the sout inputs to any output.

Decomposition:
- Package alkcflag_pkg:
  - op encoding constants ALKF_NOP..ALKF_TOG (3-bit).
  - function alkf_next(op, cur, c, shr, shl) returning the next single-flag value.
- Sub-module alkcflag_stack: LIFO of DEPTH x N_FLAGS.
  - Inputs: push/pop/din.
  - Outputs: top/cnt/ovf/unf, with the full/empty/simultaneous rules above.
- The top level holds the flag register, the op mux and the pop/op merge.

Test Plan:
- Reset then ADD: reset, then op=ADD, sel=2, c32_in_h=1 -> flags_h=4'b0100 next cycle. Then SUB with c=1, sel=2 -> 4'b0000.
- long_lit and SHR: op=SET, sel=1, long_lit_l=0 -> flags unchanged. Then long_lit_l=1, op=SHR, sel=3, sout_shr_h=1 -> 4'b1000.
- Push with op, then pop with op: flags=4'b1010; push_h=1 with op=SET, sel=0 -> stk_cnt_h=1, flags=4'b1011. Then pop_h=1 with op=TOG, sel=2 -> flags=4'b1110 (restored 1010 with bit2 toggled), cnt=0.
- Overflow: DEPTH=4; five consecutive pushes -> cnt saturates at 4, stk_ovf_h=1 from the cycle after the 5th push. Four pops return the pushed vectors in reverse order.
- Underflow and simultaneous push/pop: pop on empty -> flags unchanged, stk_unf_h=1. push_h=pop_h=1 with cnt=2 -> cnt stays 2, no error flags set.
- Reset mid-operation: after 3 pushes and flags=4'b1111, reset_h=1 with push_h=1 and op=CLR -> all outputs 0 next cycle.
